// File: rtl/sumcheck_round_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : sumcheck_round_collector_if
//  Brief    : Prover-side write stream plus host-side round record bundle
//             for the sumcheck round collector.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef F_NBITS
`define F_NBITS 32
`endif

interface sumcheck_round_collector_if #(
    parameter int NBITS  = `F_NBITS,
    parameter int NWORDS = 8
) ();

    localparam int c_cnt_w = $clog2(NWORDS + 1);

    // Prover side
    logic                     restart;
    logic                     f_wren;
    logic                     p_wren;
    logic [NBITS-1:0]         fp_data;
    logic                     round_done;
    logic [1:0]               round_code;

    // Host / verifier side
    logic                     out_valid;
    logic                     out_ready;
    logic [NWORDS*NBITS-1:0]  out_data;
    logic [c_cnt_w-1:0]       out_count;
    logic [1:0]               out_code;
    logic                     out_pphase;
    logic                     hold_prover;
    logic                     err_overflow;
    logic                     err_mix;

    // Environment side: drives the prover stream and consumes records
    modport master (
        output restart, f_wren, p_wren, fp_data, round_done, round_code, out_ready,
        input  out_valid, out_data, out_count, out_code, out_pphase,
               hold_prover, err_overflow, err_mix
    );

    // Collector side
    modport slave (
        input  restart, f_wren, p_wren, fp_data, round_done, round_code, out_ready,
        output out_valid, out_data, out_count, out_code, out_pphase,
               hold_prover, err_overflow, err_mix
    );

endinterface

`default_nettype wire

// File: rtl/sumcheck_round_collector.sv
`default_nettype none
// ============================================================================
//  Module   : sumcheck_round_collector
//  Brief    : Frames the prover fp_data stream into one record per sumcheck
//             round and holds records in a 2-slot ping-pong buffer until the
//             host pops them. Raises hold_prover when both slots are full.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef F_NBITS
`define F_NBITS 32
`endif

module sumcheck_round_collector #(
    parameter int NBITS  = `F_NBITS,
    parameter int NWORDS = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rstb,
    sumcheck_round_collector_if.slave  bus
);

    localparam int               c_cw        = $clog2(NWORDS + 1);
    localparam logic [c_cw-1:0]  c_full_cnt  = c_cw'(NWORDS);

    // Per-slot state encoding
    localparam logic [1:0] c_empty     = 2'd0;
    localparam logic [1:0] c_filling   = 2'd1;
    localparam logic [1:0] c_committed = 2'd2;

    // Slot storage
    logic [1:0]        r_state  [2];
    logic [c_cw-1:0]   r_count  [2];
    logic [1:0]        r_code   [2];
    logic              r_pphase [2];
    logic [NBITS-1:0]  r_words  [2][NWORDS];

    logic              r_fill;
    logic              r_head;
    logic [c_cw-1:0]   r_wcnt;
    logic              r_err_ovf;
    logic              r_err_mix;

    // Registered host-side view
    logic                     r_out_valid;
    logic [NWORDS*NBITS-1:0]  r_out_data;
    logic [c_cw-1:0]          r_out_count;
    logic [1:0]               r_out_code;
    logic                     r_out_pphase;
    logic                     r_hold;

    // Next-state values
    logic [1:0]        w_state_nxt  [2];
    logic [c_cw-1:0]   w_count_nxt  [2];
    logic [1:0]        w_code_nxt   [2];
    logic              w_pphase_nxt [2];
    logic [NBITS-1:0]  w_words_nxt  [2][NWORDS];
    logic              w_fill_nxt;
    logic              w_head_nxt;
    logic [c_cw-1:0]   w_wcnt_nxt;
    logic              w_err_ovf_nxt;
    logic              w_err_mix_nxt;
    logic              w_head_valid;
    logic [NWORDS*NBITS-1:0] w_head_data;

    logic w_wr;
    logic w_fill_open;
    logic w_pop;

    assign w_wr        = bus.f_wren | bus.p_wren;
    // The fill slot is only unavailable when it still holds an unpopped
    // record, which can only happen when both slots are committed.
    assign w_fill_open = (r_state[r_fill] != c_committed);
    assign w_pop       = r_out_valid & bus.out_ready;

    // Next-state: word capture, round commit and head pop
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_code_nxt    = r_code;
        w_pphase_nxt  = r_pphase;
        w_words_nxt   = r_words;
        w_fill_nxt    = r_fill;
        w_head_nxt    = r_head;
        w_wcnt_nxt    = r_wcnt;
        w_err_ovf_nxt = r_err_ovf;
        w_err_mix_nxt = r_err_mix;

        if (w_wr) begin
            if (bus.f_wren && bus.p_wren) begin
                w_err_mix_nxt = 1'b1;
            end
            if (!w_fill_open) begin
                w_err_ovf_nxt = 1'b1;
            end else begin
                // Kind of the round is fixed by its first word
                if ((r_wcnt != '0) && (bus.p_wren != r_pphase[r_fill])) begin
                    w_err_mix_nxt = 1'b1;
                end
                if (r_wcnt == c_full_cnt) begin
                    w_err_ovf_nxt = 1'b1;
                end else begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (r_wcnt == c_cw'(k)) begin
                            w_words_nxt[r_fill][k] = bus.fp_data;
                        end
                    end
                    if (r_wcnt == '0) begin
                        w_pphase_nxt[r_fill] = bus.p_wren;
                    end
                    w_state_nxt[r_fill] = c_filling;
                    w_wcnt_nxt          = r_wcnt + c_cw'(1);
                end
            end
        end

        // A same-cycle write is already counted in w_wcnt_nxt
        if (bus.round_done && w_fill_open && (w_wcnt_nxt != '0)) begin
            w_state_nxt[r_fill] = c_committed;
            w_count_nxt[r_fill] = w_wcnt_nxt;
            w_code_nxt[r_fill]  = bus.round_code;
            w_fill_nxt          = ~r_fill;
            w_wcnt_nxt          = '0;
        end

        // Commit and pop never target the same slot
        if (w_pop) begin
            w_state_nxt[r_head]  = c_empty;
            w_count_nxt[r_head]  = '0;
            w_code_nxt[r_head]   = 2'b00;
            w_pphase_nxt[r_head] = 1'b0;
            for (int k = 0; k < NWORDS; k++) begin
                w_words_nxt[r_head][k] = '0;
            end
            w_head_nxt = ~r_head;
        end

        w_head_valid = (w_state_nxt[w_head_nxt] == c_committed);
    end

    // Flatten the upcoming head slot into the output bus layout
    for (genvar k = 0; k < NWORDS; k++) begin : g_pack
        assign w_head_data[k*NBITS +: NBITS] = w_words_nxt[w_head_nxt][k];
    end

    // State and registered outputs; restart behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rstb || bus.restart) begin
            for (int s = 0; s < 2; s++) begin
                r_state[s]  <= c_empty;
                r_count[s]  <= '0;
                r_code[s]   <= 2'b00;
                r_pphase[s] <= 1'b0;
                for (int k = 0; k < NWORDS; k++) begin
                    r_words[s][k] <= '0;
                end
            end
            r_fill       <= 1'b0;
            r_head       <= 1'b0;
            r_wcnt       <= '0;
            r_err_ovf    <= 1'b0;
            r_err_mix    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
            r_out_code   <= 2'b00;
            r_out_pphase <= 1'b0;
            r_hold       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_code       <= w_code_nxt;
            r_pphase     <= w_pphase_nxt;
            r_words      <= w_words_nxt;
            r_fill       <= w_fill_nxt;
            r_head       <= w_head_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_err_ovf    <= w_err_ovf_nxt;
            r_err_mix    <= w_err_mix_nxt;
            r_out_valid  <= w_head_valid;
            r_out_data   <= w_head_valid ? w_head_data : '0;
            r_out_count  <= w_head_valid ? w_count_nxt[w_head_nxt] : '0;
            r_out_code   <= w_head_valid ? w_code_nxt[w_head_nxt] : 2'b00;
            r_out_pphase <= w_head_valid ? w_pphase_nxt[w_head_nxt] : 1'b0;
            r_hold       <= (w_state_nxt[0] == c_committed) &&
                            (w_state_nxt[1] == c_committed);
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_count    = r_out_count;
    assign bus.out_code     = r_out_code;
    assign bus.out_pphase   = r_out_pphase;
    assign bus.hold_prover  = r_hold;
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_mix      = r_err_mix;

endmodule

`default_nettype wire

// File: tb/tb_sumcheck_round_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sumcheck_round_collector
//  Brief    : Self-checking bench: directed vector table, hand sequences for
//             back-pressure and restart, and random traffic against a
//             record-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sumcheck_round_collector;

    localparam int NB = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rstb;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sumcheck_round_collector_if #(.NBITS(NB), .NWORDS(NW)) bus ();

    sumcheck_round_collector #(.NBITS(NB), .NWORDS(NW)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // ---------------- reference model: queue of committed records ----------
    typedef struct {
        logic [3:0]       count;
        logic [1:0]       code;
        logic             pph;
        logic [NW*NB-1:0] data;
    } rec_t;

    rec_t          m_q[$];
    logic [NB-1:0] m_cur[$];
    logic          m_kind;
    logic          m_ovf;
    logic          m_mix;

    task automatic model_clear();
        m_q.delete();
        m_cur.delete();
        m_kind = 1'b0;
        m_ovf  = 1'b0;
        m_mix  = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic p, input logic [NB-1:0] d,
                              input logic done, input logic [1:0] code,
                              input logic ready, input logic clr);
        logic full;
        logic pop;
        logic commit;
        rec_t r;
        if (clr) begin
            model_clear();
            return;
        end
        full   = (m_q.size() == 2);
        pop    = (m_q.size() > 0) && ready;
        commit = 1'b0;
        if (f && p) m_mix = 1'b1;
        if (f || p) begin
            if (full) begin
                m_ovf = 1'b1;
            end else begin
                if (m_cur.size() > 0 && p != m_kind) m_mix = 1'b1;
                if (m_cur.size() == NW) begin
                    m_ovf = 1'b1;
                end else begin
                    if (m_cur.size() == 0) m_kind = p;
                    m_cur.push_back(d);
                end
            end
        end
        if (done && !full && m_cur.size() > 0) begin
            r.count = 4'(m_cur.size());
            r.code  = code;
            r.pph   = m_kind;
            r.data  = '0;
            for (int i = 0; i < m_cur.size(); i++) r.data[i*NB +: NB] = m_cur[i];
            commit = 1'b1;
            m_cur.delete();
        end
        if (pop) void'(m_q.pop_front());
        if (commit) m_q.push_back(r);
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic v;
        v = (m_q.size() > 0);
        chk("valid", bus.out_valid, v);
        chk("count", bus.out_count, v ? m_q[0].count : 4'd0);
        chk("code", bus.out_code, v ? m_q[0].code : 2'd0);
        chk("pphase", bus.out_pphase, v ? m_q[0].pph : 1'b0);
        chk("data", bus.out_data, v ? m_q[0].data : '0);
        chk("hold", bus.hold_prover, m_q.size() == 2);
        chk("err_ovf", bus.err_overflow, m_ovf);
        chk("err_mix", bus.err_mix, m_mix);
    endtask

    // One clock: drive away from the edge, update model at the edge, sample after it
    task automatic step(input logic f, input logic p, input logic [NB-1:0] d,
                        input logic done, input logic [1:0] code,
                        input logic ready, input logic rs, input logic rst_i);
        @(negedge clk);
        bus.f_wren     = f;
        bus.p_wren     = p;
        bus.fp_data    = d;
        bus.round_done = done;
        bus.round_code = code;
        bus.out_ready  = ready;
        bus.restart    = rs;
        rstb           = rst_i;
        @(posedge clk);
        model_step(f, p, d, done, code, ready, rs | rst_i);
        #1;
        model_compare();
    endtask

    task automatic idle(input logic ready);
        step(1'b0, 1'b0, '0, 1'b0, 2'b00, ready, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic f, p;
        logic [NB-1:0] d;
        logic done;
        logic [1:0] code;
        logic ready;
        logic e_valid;
        logic [3:0] e_count;
        logic e_hold, e_ovf, e_mix;
        logic [NB-1:0] e_w0;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, input logic p, input logic [NB-1:0] d,
                       input logic done, input logic [1:0] code, input logic ready,
                       input logic ev, input logic [3:0] ec, input logic eh,
                       input logic eo, input logic em, input logic [NB-1:0] ew);
        vec_t v;
        v.f = f; v.p = p; v.d = d; v.done = done; v.code = code; v.ready = ready;
        v.e_valid = ev; v.e_count = ec; v.e_hold = eh; v.e_ovf = eo; v.e_mix = em;
        v.e_w0 = ew;
        vecs.push_back(v);
    endtask

    initial begin
        bus.f_wren = 0; bus.p_wren = 0; bus.fp_data = '0; bus.round_done = 0;
        bus.round_code = 0; bus.out_ready = 0; bus.restart = 0; rstb = 1'b1;
        model_clear();

        // Full 8-word F round, code 01, then pop
        for (int k = 1; k <= 8; k++) add(1, 0, NB'(k), 0, 2'b00, 0, 0, 0, 0, 0, 0, '0);
        add(0, 0, '0, 1, 2'b01, 0, 1, 8, 0, 0, 0, 16'h0001);
        add(0, 0, '0, 0, 2'b00, 1, 0, 0, 0, 0, 0, '0);
        // Write coincident with round_done; empty round_done makes no record
        add(1, 0, 16'h0011, 0, 2'b00, 0, 0, 0, 0, 0, 0, '0);
        add(1, 0, 16'h0012, 0, 2'b00, 0, 0, 0, 0, 0, 0, '0);
        add(1, 0, 16'h0013, 1, 2'b10, 0, 1, 3, 0, 0, 0, 16'h0011);
        add(0, 0, '0, 0, 2'b00, 1, 0, 0, 0, 0, 0, '0);
        add(0, 0, '0, 1, 2'b11, 0, 0, 0, 0, 0, 0, '0);
        add(0, 0, '0, 0, 2'b00, 0, 0, 0, 0, 0, 0, '0);
        // Mixed kinds in one round
        add(1, 0, 16'h0021, 0, 2'b00, 0, 0, 0, 0, 0, 0, '0);
        add(0, 1, 16'h0022, 0, 2'b00, 0, 0, 0, 0, 0, 1, '0);
        add(0, 0, '0, 1, 2'b11, 0, 1, 2, 0, 0, 1, 16'h0021);
        add(0, 0, '0, 0, 2'b00, 1, 0, 0, 0, 0, 1, '0);
        // Nine writes into an eight-word round
        for (int k = 1; k <= 8; k++) add(1, 0, NB'(16'h0030 + k), 0, 2'b00, 0, 0, 0, 0, 0, 1, '0);
        add(1, 0, 16'h0039, 0, 2'b00, 0, 0, 0, 0, 1, 1, '0);
        add(0, 0, '0, 1, 2'b00, 0, 1, 8, 0, 1, 1, 16'h0031);
        add(0, 0, '0, 0, 2'b00, 1, 0, 0, 0, 1, 1, '0);

        // Reset held for two cycles
        step(0, 0, '0, 0, 2'b00, 0, 0, 1);
        step(0, 0, '0, 0, 2'b00, 0, 0, 1);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_hold", bus.hold_prover, 1'b0);
        chk("rst_errs", {bus.err_overflow, bus.err_mix}, 2'b00);
        chk("rst_data", bus.out_data, '0);

        foreach (vecs[i]) begin
            step(vecs[i].f, vecs[i].p, vecs[i].d, vecs[i].done, vecs[i].code,
                 vecs[i].ready, 1'b0, 1'b0);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_count", i), bus.out_count, vecs[i].e_count);
            chk($sformatf("vec%0d_hold", i), bus.hold_prover, vecs[i].e_hold);
            chk($sformatf("vec%0d_ovf", i), bus.err_overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d_mix", i), bus.err_mix, vecs[i].e_mix);
            chk($sformatf("vec%0d_w0", i), bus.out_data[NB-1:0], vecs[i].e_w0);
        end

        // Back-pressure: three P rounds with no consumer
        step(0, 0, '0, 0, 2'b00, 0, 1, 0);
        for (int r = 1; r <= 3; r++) begin
            for (int k = 1; k <= 3; k++) step(0, 1, NB'(r * 256 + k), 0, 2'b00, 0, 0, 0);
            step(0, 0, '0, 1, 2'(r), 0, 0, 0);
            if (r == 2) chk("bp_hold_after_2", bus.hold_prover, 1'b1);
        end
        chk("bp_ovf", bus.err_overflow, 1'b1);
        chk("bp_round1", bus.out_data[3*NB-1:0], 48'h0103_0102_0101);
        chk("bp_round1_code", bus.out_code, 2'd1);
        step(0, 0, '0, 0, 2'b00, 1, 0, 0);
        chk("bp_round2", bus.out_data[3*NB-1:0], 48'h0203_0202_0201);
        chk("bp_round2_cnt", bus.out_count, 4'd3);
        chk("bp_round2_pph", bus.out_pphase, 1'b1);
        chk("bp_hold_clear", bus.hold_prover, 1'b0);
        step(0, 0, '0, 0, 2'b00, 1, 0, 0);
        chk("bp_drained", bus.out_valid, 1'b0);

        // Restart mid-round with one slot committed (errors still sticky)
        step(1, 0, 16'h0a01, 0, 2'b00, 0, 0, 0);
        step(1, 0, 16'h0a02, 1, 2'b01, 0, 0, 0);
        step(1, 0, 16'h0b01, 0, 2'b00, 0, 0, 0);
        chk("rs_pre_valid", bus.out_valid, 1'b1);
        step(1, 0, 16'h0b02, 1, 2'b10, 1, 1, 0);
        chk("rs_valid", bus.out_valid, 1'b0);
        chk("rs_errs", {bus.err_overflow, bus.err_mix, bus.hold_prover}, 3'b000);
        step(1, 0, 16'h0055, 1, 2'b11, 0, 0, 0);
        chk("rs_fresh_cnt", bus.out_count, 4'd1);
        chk("rs_fresh_w0", bus.out_data[NB-1:0], 16'h0055);
        step(0, 0, '0, 0, 2'b00, 1, 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic f, p, dn, rd, rs;
            int   sel;
            sel = int'($urandom_range(0, 19));
            f   = (sel < 7) || (sel == 19);
            p   = (sel >= 7 && sel < 12) || (sel == 19);
            dn  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            step(f, p, NB'($urandom), dn, 2'($urandom), rd, rs, 1'b0);
        end
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
